mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 16, address width; DW, default 16, data width; TIMEOUT, default 255, maximum cycles to wait for memory_ready.
REQ-002 Clock and reset SHALL be one clock and an asynchronous active-low reset:
- clk  input  1  single rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
REQ-003 Requester port 0 (instruction fetch) SHALL be:
- p0_req  input  1  request, held high until acknowledged
- p0_w  input  1  1=write, 0=read
- p0_addr  input  AW  address
- p0_wdata  input  DW  write data
- p0_ack  output  1  one-cycle completion pulse
REQ-004 Requester port 1 (data) SHALL have the same five signals, prefixed p1_.
REQ-005 Shared result outputs SHALL be:
- rd_data  output  DW  read data, valid while any ack is high
- err  output  1  timeout flag, valid while any ack is high
REQ-006 Memory side SHALL be:
- mem_addr  output  AW  registered address
- mem_w  output  1  registered write strobe
- mem_wdata  output  DW  registered write data
- mem_rdata  input  DW  read data
- memory_ready  input  1  1=idle or complete, 0=busy
REQ-007 Status outputs SHALL be:
- busy  output  1  high in every state except IDLE
- grant  output  1  index of the current or last granted port

Function
REQ-008 The FSM SHALL have four states, IDLE, ISSUE, WAIT and DONE, each lasting at least one cycle.
REQ-009 In IDLE, requests SHALL be sampled on each edge. If any req is high, the arbiter SHALL choose a winner, latch its addr/w/wdata into mem_addr/mem_w/mem_wdata, set grant, and go to ISSUE. Requests SHALL be ignored in all other states.
REQ-010 Arbitration SHALL be round-robin:
- single requester: that port wins
- both requesting: the port not granted last wins
- the last-grant pointer updates on each grant
REQ-011 ISSUE SHALL last exactly one cycle and then go to WAIT; memory_ready SHALL NOT be sampled in ISSUE, so the memory sees the new address before the first sample.
REQ-012 In WAIT, sampling memory_ready=1 SHALL:
- capture mem_rdata into rd_data if mem_w=0 (rd_data is left unchanged on writes)
- set err=0
- go to DONE
REQ-013 WAIT SHALL count cycles from 1. If memory_ready is still 0 after TIMEOUT WAIT cycles, the FSM SHALL go to DONE with err=1 and rd_data=0.
REQ-014 In DONE, the winner's ack SHALL be high for exactly that one cycle, the other ack SHALL stay low, and the next state SHALL be IDLE.
REQ-015 The requester SHALL drop req at the edge that ends its ack cycle; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-016 mem_addr, mem_w and mem_wdata SHALL hold their values from grant through the end of DONE, and SHALL keep their last values in IDLE. mem_w SHALL be ignored by the memory unless mem_addr changes.
REQ-017 A request to the same address as the previous transfer SHALL complete normally; if memory_ready never drops, the first WAIT sample SHALL complete it.
REQ-018 Changes on a losing port's req/addr/wdata during a transfer SHALL have no effect.

Reset
REQ-019 While rst_n=0, regardless of the clock, the block SHALL hold:
- state = IDLE
- mem_addr, mem_w, mem_wdata = 0
- p0_ack, p1_ack, err = 0; rd_data = 0
- grant = 0; last-grant pointer = 1 (port 0 preferred first)
- timeout counter = 0
REQ-020 Reset during ISSUE, WAIT or DONE SHALL abandon the transfer with no ack; on release the arbiter SHALL start in IDLE.

Verification
REQ-021 p0 read of 0x0010, memory model (ready drops 1 edge after the address change, recovers 1 edge later for reads and 2 for writes) -> mem_addr=0x0010 after grant edge E0; p0_ack high in the cycle after E3; rd_data=mem_rdata; err=0.
REQ-022 p1 write 0x0020/0xBEEF -> mem_w=1, mem_wdata=0xBEEF; p1_ack high in the cycle after E4; rd_data unchanged.
REQ-023 p0 and p1 requesting together from reset, both re-asserting after each ack -> grant order 0,1,0,1; no cycle with both acks high.
REQ-024 memory_ready tied 0 with TIMEOUT=8 -> ack in the cycle after the 8th WAIT cycle; err=1; rd_data=0; back to IDLE.
REQ-025 rst_n pulsed low during WAIT -> all outputs at reset values immediately; no ack; a new p1 request after release completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port round-robin arbiter in front of a single memory with a ready/busy
// handshake. Port 0 is the instruction-fetch requester and port 1 the data
// requester. One transfer runs at a time through IDLE -> ISSUE -> WAIT -> DONE.
// The winner's ack is a one-cycle pulse in DONE. A WAIT phase that outlasts
// TIMEOUT cycles ends the transfer with err=1 and rd_data=0.
//
// Ports
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   pN_req                  request, held high until acknowledged (N = 0, 1)
//   pN_w                    1 = write, 0 = read
//   pN_addr, pN_wdata       address and write data of requester N
//   pN_ack                  one-cycle completion pulse for requester N
//   rd_data, err            shared result, valid while any ack is high
//   mem_addr, mem_w,        registered memory command, held from grant to the
//   mem_wdata               end of DONE and kept in IDLE
//   mem_rdata               memory read data
//   memory_ready            1 = idle or complete, 0 = busy
//   busy                    high in every state except IDLE
//   grant                   index of the current or last granted port
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          p0_req,
   input  logic          p0_w,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic          p0_ack,
   input  logic          p1_req,
   input  logic          p1_w,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic          p1_ack,
   output logic [DW-1:0] rd_data,
   output logic          err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_w,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          memory_ready,
   output logic          busy,
   output logic          grant
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // The counter holds the number of WAIT samples already seen with
   // memory_ready low, so its largest value is TIMEOUT-1.
   localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          w_q, w_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rd_q, rd_d;
   logic          err_q, err_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic          grant_q, grant_d;
   logic          last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          win;

   // Round-robin choice: a lone requester wins outright; with both requesting
   // the port that did not win last time goes first.
   always_comb begin
      if (p0_req && p1_req) begin
         win = ~last_q;
      end else begin
         win = p1_req;
      end
   end

   always_comb begin
      // NOTE: every _d starts from its _q (acks from 0) so that no path through
      //       the case leaves a variable unassigned and infers a latch.
      state_d = state_q;
      addr_d  = addr_q;
      w_d     = w_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      err_d   = err_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (p0_req || p1_req) begin
               grant_d = win;
               last_d  = win;
               addr_d  = win ? p1_addr  : p0_addr;
               w_d     = win ? p1_w     : p0_w;
               wdata_d = win ? p1_wdata : p0_wdata;
               state_d = S_ISSUE;
            end
         end

         // memory_ready is deliberately not looked at here: the memory needs
         // one edge to see the new address before its status means anything.
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (memory_ready) begin
               if (!w_q) begin
                  rd_d = mem_rdata;
               end
               err_d   = 1'b0;
               ack0_d  = ~grant_q;
               ack1_d  = grant_q;
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               rd_d    = '0;
               ack0_d  = ~grant_q;
               ack1_d  = grant_q;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   //       samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         w_q     <= 1'b0;
         wdata_q <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;   // port 0 is preferred on the first contended grant
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         w_q     <= w_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign p0_ack    = ack0_q;
   assign p1_ack    = ack1_q;
   assign rd_data   = rd_q;
   assign err       = err_q;
   assign mem_addr  = addr_q;
   assign mem_w     = w_q;
   assign mem_wdata = wdata_q;
   assign grant     = grant_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter (TIMEOUT=8). A behavioural memory drives
// memory_ready/mem_rdata: ready drops one edge after an address change and
// recovers after a latency (1 edge for reads and 2 for writes, a random
// latency, or never). A transaction-level reference model predicts grants,
// ack timing and results from the arbitration and timing rules. One compare
// process checks the DUT against it on every cycle out of reset. Directed
// scenarios pin the model with hand-computed literals, and a randomized phase
// follows.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 8;

   logic          clk;
   logic          rst_n;
   logic [1:0]    req;
   logic [1:0]    pw;
   logic [AW-1:0] paddr  [2];
   logic [DW-1:0] pwdata [2];
   logic          p0_ack, p1_ack;
   logic [DW-1:0] rd_data;
   logic          err;
   logic [AW-1:0] mem_addr;
   logic          mem_w;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          memory_ready;
   logic          busy;
   logic          grant;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;
   int mem_mode = 0;   // 0: read 1 / write 2 edges, 1: random 0..10, 2: never ready

   mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .p0_req       (req[0]),
      .p0_w         (pw[0]),
      .p0_addr      (paddr[0]),
      .p0_wdata     (pwdata[0]),
      .p0_ack       (p0_ack),
      .p1_req       (req[1]),
      .p1_w         (pw[1]),
      .p1_addr      (paddr[1]),
      .p1_wdata     (pwdata[1]),
      .p1_ack       (p1_ack),
      .rd_data      (rd_data),
      .err          (err),
      .mem_addr     (mem_addr),
      .mem_w        (mem_w),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .memory_ready (memory_ready),
      .busy         (busy),
      .grant        (grant)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      edge_n++;
   end

   // Memory contents: a fixed function of the address.
   function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
      return DW'(a) ^ 16'h5A5A;
   endfunction

   function automatic logic [AW-1:0] pick_addr();
      return AW'($urandom_range(1, 4) * 16);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural memory (updates on the falling edge) ---------
   initial begin : mem_model
      logic [AW-1:0] seen;
      int            since;
      int            lat;
      seen         = '0;
      since        = 100;
      lat          = 0;
      memory_ready = 1'b1;
      mem_rdata    = data_of('0);
      forever begin
         @(negedge clk);
         if (mem_addr !== seen) begin
            seen  = mem_addr;
            since = 0;
            lat   = (mem_mode == 0) ? (mem_w ? 2 : 1) : int'($urandom_range(0, 10));
         end else if (since < 100) begin
            since++;
         end
         memory_ready = (mem_mode == 2) ? 1'b0 : !(since >= 1 && since <= lat);
         mem_rdata    = memory_ready ? data_of(mem_addr) : DW'($urandom);
      end
   end

   // ---------------- transaction-level reference model ------------------------
   logic [1:0]    exp_ack    = '0;
   logic          exp_busy   = 1'b0;
   logic          exp_grant  = 1'b0;
   logic          exp_err    = 1'b0;
   logic          exp_mw     = 1'b0;
   logic [AW-1:0] exp_maddr  = '0;
   logic [DW-1:0] exp_mwdata = '0;
   logic [DW-1:0] exp_rd     = '0;
   bit            m_last     = 1'b1;
   bit            m_active   = 1'b0;
   bit            m_ack_cyc  = 1'b0;
   int            m_age      = 0;
   int            m_samples  = 0;
   int            n_done     = 0;

   initial begin : ref_model
      bit win;
      bit fin;
      forever begin
         @(posedge clk or negedge rst_n);
         fin = 1'b0;
         if (rst_n !== 1'b1) begin
            exp_ack = '0; exp_busy = 1'b0; exp_grant = 1'b0; exp_err = 1'b0;
            exp_mw = 1'b0; exp_maddr = '0; exp_mwdata = '0; exp_rd = '0;
            m_last = 1'b1; m_active = 1'b0; m_ack_cyc = 1'b0;
         end else if (m_ack_cyc) begin
            // the edge that ends the ack cycle ignores requests
            m_ack_cyc = 1'b0;
            exp_ack   = '0;
            exp_busy  = 1'b0;
         end else if (!m_active) begin
            if (req != 2'b00) begin
               win        = (req == 2'b11) ? !m_last : req[1];
               m_last     = win;
               exp_grant  = win;
               exp_maddr  = paddr[win];
               exp_mw     = pw[win];
               exp_mwdata = pwdata[win];
               exp_busy   = 1'b1;
               m_active   = 1'b1;
               m_age      = 0;
               m_samples  = 0;
            end
         end else begin
            m_age++;
            if (m_age >= 2) begin   // first edge after grant is the unsampled issue cycle
               m_samples++;
               if (memory_ready) begin
                  if (!exp_mw) exp_rd = data_of(exp_maddr);
                  exp_err = 1'b0;
                  fin     = 1'b1;
               end else if (m_samples == TO) begin
                  exp_err = 1'b1;
                  exp_rd  = '0;
                  fin     = 1'b1;
               end
            end
            if (fin) begin
               m_active           = 1'b0;
               m_ack_cyc          = 1'b1;
               exp_ack[exp_grant] = 1'b1;
               n_done++;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------------------------------
   initial forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
         check("busy",      busy,      exp_busy);
         check("grant",     grant,     exp_grant);
         check("p0_ack",    p0_ack,    exp_ack[0]);
         check("p1_ack",    p1_ack,    exp_ack[1]);
         check("mem_addr",  mem_addr,  exp_maddr);
         check("mem_w",     mem_w,     exp_mw);
         check("mem_wdata", mem_wdata, exp_mwdata);
         if (exp_ack != 2'b00) begin
            check("rd_data", rd_data, exp_rd);
            check("err",     err,     exp_err);
         end
      end
   end

   // ---------------- stimulus helpers -----------------------------------------
   task automatic drive(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      pw[p]     = w;
      paddr[p]  = a;
      pwdata[p] = d;
      req[p]    = 1'b1;
   endtask

   task automatic wait_ack(input int p, output int at_edge);
      at_edge = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (((p == 0) ? p0_ack : p1_ack) === 1'b1) begin
            at_edge = edge_n;
            break;
         end
      end
   endtask

   task automatic wait_any(output int who);
      who = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (p0_ack === 1'b1) begin who = 0; break; end
         if (p1_ack === 1'b1) begin who = 1; break; end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_random(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (((p == 0) ? p0_ack : p1_ack) === 1'b1) begin
               req[p] = 1'b0;
            end else if (!req[p]) begin
               if ($urandom_range(0, 3) == 0) begin
                  drive(p, 1'($urandom), pick_addr(), DW'($urandom));
               end
            end else if (busy === 1'b1 && $urandom_range(0, 1) == 1) begin
               // wiggle a pending or already-latched request; must not matter
               pw[p]     = 1'($urandom);
               paddr[p]  = pick_addr();
               pwdata[p] = DW'($urandom);
            end
         end
      end
   endtask

   // ---------------- main sequence --------------------------------------------
   initial begin : main
      int e0;
      int at;
      int who;
      int d0;
      int order [4];

      rst_n = 1'b0;
      req   = '0;
      pw    = '0;
      for (int p = 0; p < 2; p++) begin
         paddr[p]  = '0;
         pwdata[p] = '0;
      end
      repeat (3) @(negedge clk);

      check("rst_busy",      busy,      0);
      check("rst_grant",     grant,     0);
      check("rst_p0_ack",    p0_ack,    0);
      check("rst_p1_ack",    p1_ack,    0);
      check("rst_mem_addr",  mem_addr,  0);
      check("rst_mem_w",     mem_w,     0);
      check("rst_err",       err,       0);
      check("rst_rd_data",   rd_data,   0);
      rst_n = 1'b1;
      @(negedge clk);

      // p0 read of 0x0010
      drive(0, 1'b0, 16'h0010, 16'h0000);
      e0 = edge_n + 1;
      @(negedge clk);
      check("rd_mem_addr", mem_addr, 16'h0010);
      check("rd_grant",    grant,    0);
      wait_ack(0, at);
      check("rd_ack_edge", at,      e0 + 3);
      check("rd_data_val", rd_data, 16'h5A4A);
      check("rd_err",      err,     0);
      req[0] = 1'b0;
      @(negedge clk);

      // p1 write 0x0020 / 0xBEEF
      drive(1, 1'b1, 16'h0020, 16'hBEEF);
      e0 = edge_n + 1;
      @(negedge clk);
      check("wr_mem_w",     mem_w,     1);
      check("wr_mem_wdata", mem_wdata, 16'hBEEF);
      check("wr_grant",     grant,     1);
      wait_ack(1, at);
      check("wr_ack_edge",  at,        e0 + 4);
      check("wr_rd_keep",   rd_data,   16'h5A4A);
      check("wr_p0_quiet",  p0_ack,    0);
      req[1] = 1'b0;

      // both requesting from reset, re-asserting after each ack
      do_reset();
      drive(0, 1'b0, 16'h0010, 16'h0000);
      drive(1, 1'b0, 16'h0020, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         wait_any(who);
         order[k] = who;
         if (who < 0) break;
         req[who] = 1'b0;
         if (k < 3) begin
            @(negedge clk);
            req[who] = 1'b1;
         end
      end
      req = '0;
      for (int k = 0; k < 4; k++) check($sformatf("rr_order_%0d", k), order[k], k % 2);
      @(negedge clk);

      // memory never ready -> timeout after 8 WAIT cycles
      mem_mode = 2;
      @(negedge clk);
      drive(0, 1'b0, 16'h0030, 16'h0000);
      e0 = edge_n + 1;
      wait_ack(0, at);
      check("to_ack_edge", at,      e0 + 9);
      check("to_err",      err,     1);
      check("to_rd_zero",  rd_data, 0);
      req[0] = 1'b0;
      mem_mode = 0;
      @(negedge clk);
      check("to_idle", busy, 0);
      @(negedge clk);

      // reset pulsed during WAIT
      drive(0, 1'b0, 16'h0040, 16'h1234);
      e0 = edge_n + 1;
      repeat (2) @(negedge clk);
      #2;
      rst_n  = 1'b0;
      req[0] = 1'b0;
      #1;
      check("mid_rst_busy",      busy,      0);
      check("mid_rst_mem_addr",  mem_addr,  0);
      check("mid_rst_mem_wdata", mem_wdata, 0);
      check("mid_rst_err",       err,       0);
      check("mid_rst_p0_ack",    p0_ack,    0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mid_rst_no_ack", {p1_ack, p0_ack}, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      drive(1, 1'b0, 16'h0020, 16'h0000);
      e0 = edge_n + 1;
      wait_ack(1, at);
      check("post_rst_ack_edge", at,      e0 + 3);
      check("post_rst_rd",       rd_data, 16'h5A7A);
      check("post_rst_grant",    grant,   1);
      req[1] = 1'b0;
      @(negedge clk);

      // same address again: ready never drops, first WAIT sample completes
      drive(1, 1'b0, 16'h0020, 16'h0000);
      e0 = edge_n + 1;
      wait_ack(1, at);
      check("same_addr_ack_edge", at,      e0 + 2);
      check("same_addr_rd",       rd_data, 16'h5A7A);
      req[1] = 1'b0;
      @(negedge clk);

      // randomized traffic with random memory latency (some time out)
      mem_mode = 1;
      d0 = n_done;
      run_random(3000);
      req = '0;
      repeat (40) @(negedge clk);
      check("rand_txn_count", (n_done - d0) > 50, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
